// File: rtl/a2d_spi_intf.sv
// a2d_spi_intf: SPI master for a 12-bit ADC.
// One conversion is two 16-bit frames: frame 1 sends the channel command,
// frame 2 resends it and clocks back the conversion result. SCLK is clk/32.
module a2d_spi_intf #(
  parameter int GAP_CLKS = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        strt_cnv,
  input  logic [2:0]  chnnl,
  input  logic        MISO,
  output logic        SS_n,
  output logic        SCLK,
  output logic        MOSI,
  output logic        cnv_cmplt,
  output logic [11:0] res
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    FRM1 = 3'd1,
    GAP  = 3'd2,
    FRM2 = 3'd3,
    DONE = 3'd4
  } state_t;

  // Gap counter starts at 0 on the edge SS_n rises; FRM2 is entered one
  // edge before SS_n falls again, so the terminal count is GAP_CLKS-2.
  localparam logic [7:0] GAP_LAST  = 8'(GAP_CLKS - 2);
  // Divider preload puts SCLK high, then the first fall comes 9 clks later.
  localparam logic [4:0] DIV_LOAD  = 5'b10111;
  localparam logic [4:0] DIV_RISE  = 5'b01111;
  localparam logic [4:0] DIV_END   = 5'b11110;
  localparam logic [4:0] RISES_FRM = 5'd16;

  state_t      r_state;
  logic [2:0]  r_ch;
  logic [15:0] r_shft;
  logic [4:0]  r_div;
  logic [4:0]  r_rise;
  logic [7:0]  r_gap;
  logic        r_start;
  logic        r_ss_n;
  logic        r_cmplt;
  logic [11:0] r_res;

  logic        w_rise;
  logic        w_frm_end;

  assign w_rise    = (r_div == DIV_RISE);
  assign w_frm_end = (r_div == DIV_END) && (r_rise == RISES_FRM);

  // Transaction FSM: frame sequencing, SCLK divider, shifting and result capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_ch    <= 3'b000;
      r_shft  <= 16'h0000;
      r_div   <= 5'd0;
      r_rise  <= 5'd0;
      r_gap   <= 8'd0;
      r_start <= 1'b0;
      r_ss_n  <= 1'b1;
      r_cmplt <= 1'b0;
      r_res   <= 12'h000;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (strt_cnv) begin
            r_ch    <= chnnl;
            r_shft  <= {2'b00, chnnl, 11'h000};
            r_cmplt <= 1'b0;
            r_start <= 1'b1;
            r_state <= FRM1;
          end
        end
        FRM1, FRM2: begin
          if (r_start) begin
            // Frame start: drop SS_n one edge after the command is loaded.
            r_start <= 1'b0;
            r_ss_n  <= 1'b0;
            r_div   <= DIV_LOAD;
            r_rise  <= 5'd0;
          end else begin
            r_div <= r_div + 5'd1;
            if (w_rise) begin
              r_shft <= {r_shft[14:0], MISO};
              r_rise <= r_rise + 5'd1;
            end
            if (w_frm_end) begin
              r_ss_n <= 1'b1;
              if (r_state == FRM1) begin
                r_gap   <= 8'd0;
                r_state <= GAP;
              end else begin
                r_res   <= r_shft[11:0];
                r_cmplt <= 1'b1;
                r_state <= DONE;
              end
            end
          end
        end
        GAP: begin
          if (r_gap == GAP_LAST) begin
            r_shft  <= {2'b00, r_ch, 11'h000};
            r_start <= 1'b1;
            r_state <= FRM2;
          end else begin
            r_gap <= r_gap + 8'd1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_ss_n  <= 1'b1;
        end
      endcase
    end
  end

  assign SS_n      = r_ss_n;
  assign SCLK      = r_ss_n | r_div[4];
  assign MOSI      = r_shft[15];
  assign cnv_cmplt = r_cmplt;
  assign res       = r_res;

endmodule

// File: tb/tb_a2d_spi_intf.sv
// tb_a2d_spi_intf: directed + randomized bench for a2d_spi_intf with an ADC
// model on MISO and a bus monitor measuring SS_n windows, SCLK rises and MOSI words.
module tb_a2d_spi_intf;

  localparam int GAP    = 32;
  localparam int SCLK_P = 32;                    // clk cycles per SCLK period
  localparam int LOW_W  = 16 * SCLK_P + 8;       // SS_n low width per frame
  localparam int LAT    = 1 + LOW_W + GAP + LOW_W; // accept edge to cnv_cmplt edge

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        strt_cnv = 1'b0;
  logic [2:0]  chnnl = 3'b000;
  logic        MISO;
  logic        SS_n;
  logic        SCLK;
  logic        MOSI;
  logic        cnv_cmplt;
  logic [11:0] res;

  a2d_spi_intf #(.GAP_CLKS(GAP)) dut (
    .clk       (clk),
    .rst       (rst),
    .strt_cnv  (strt_cnv),
    .chnnl     (chnnl),
    .MISO      (MISO),
    .SS_n      (SS_n),
    .SCLK      (SCLK),
    .MOSI      (MOSI),
    .cnv_cmplt (cnv_cmplt),
    .res       (res)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  // Bus monitor state and per-window records.
  logic        m_ss_prev   = 1'b1;
  logic        m_sclk_prev = 1'b1;
  int          m_low  = 0;
  int          m_high = 0;
  bit          m_high_valid = 1'b0;
  logic [4:0]  m_rises = 5'd16;
  logic [15:0] m_mosi = 16'h0000;
  int          q_low[$];
  int          q_high[$];
  int          q_rise[$];
  logic [15:0] q_mosi[$];

  // ADC model: presents word MSB first, advancing one bit after each SCLK rise.
  logic [15:0] adc_word = 16'h0000;
  assign MISO = (m_rises < 5'd16) ? adc_word[4'd15 - m_rises[3:0]] : 1'b0;

  // Monitor sampled on the falling clk edge, away from DUT updates.
  always @(negedge clk) begin
    m_ss_prev   <= SS_n;
    m_sclk_prev <= SCLK;
    if (!SS_n) begin
      if (m_ss_prev) begin
        if (m_high_valid) q_high.push_back(m_high);
        m_low   <= 1;
        m_rises <= 5'd0;
        m_mosi  <= 16'h0000;
      end else begin
        m_low <= m_low + 1;
        if (!m_sclk_prev && SCLK) m_rises <= m_rises + 5'd1;
        if (m_sclk_prev && !SCLK) m_mosi <= {m_mosi[14:0], MOSI};
      end
    end else begin
      if (!m_ss_prev) begin
        q_low.push_back(m_low);
        q_rise.push_back(int'(m_rises));
        q_mosi.push_back(m_mosi);
        m_high       <= 1;
        m_high_valid <= 1'b1;
      end else begin
        m_high <= m_high + 1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One full conversion with optional ignored strt_cnv pulse at edge glitch_k.
  task automatic do_conv(input logic [2:0] ch, input logic [11:0] result,
                         input int glitch_k, input logic [2:0] glitch_ch, input string tag);
    logic [15:0] exp_mosi;
    logic [11:0] old_res;
    int t0, k, nl0, nr0, nm0, res_chg;
    bit swapped, done;
    exp_mosi = {2'b00, ch, 11'h000};
    nl0 = q_low.size();
    nr0 = q_rise.size();
    nm0 = q_mosi.size();
    adc_word = 16'($urandom);              // frame-1 data, must be discarded
    @(negedge clk);
    old_res  = res;
    strt_cnv = 1'b1;
    chnnl    = ch;
    @(negedge clk);
    strt_cnv = 1'b0;
    chnnl    = 3'($urandom);
    t0 = cyc;
    chk({tag, " cmplt_clr_E0"}, 32'(cnv_cmplt), 32'd0);
    chk({tag, " ssn_high_E0"}, 32'(SS_n), 32'd1);
    swapped = 1'b0;
    done    = 1'b0;
    res_chg = 0;
    k       = 0;
    while (!done && k < LAT + 200) begin
      @(negedge clk);
      k = cyc - t0;
      if (k == 1) chk({tag, " ssn_low_E1"}, 32'(SS_n), 32'd0);
      if (glitch_k > 0) begin
        if (k == glitch_k - 1) begin
          strt_cnv = 1'b1;
          chnnl    = glitch_ch;
        end else if (k == glitch_k) begin
          strt_cnv = 1'b0;
        end
      end
      if (!swapped && k > 1 && SS_n) begin
        adc_word = {4'($urandom), result};
        swapped  = 1'b1;
      end
      if (cnv_cmplt) done = 1'b1;
      else if (res !== old_res) res_chg++;
    end
    chk({tag, " latency"}, 32'(k), 32'(LAT));
    chk({tag, " res"}, 32'(res), 32'(result));
    chk({tag, " res_hold"}, 32'(res_chg), 32'd0);
    chk({tag, " ssn_done"}, 32'(SS_n), 32'd1);
    chk({tag, " sclk_done"}, 32'(SCLK), 32'd1);
    @(negedge clk);
    chk({tag, " frames"}, 32'(q_low.size() - nl0), 32'd2);
    for (int f = 0; f < 2; f++) begin
      if (q_low.size() > nl0 + f)  chk({tag, " low_width"}, 32'(q_low[nl0 + f]), 32'(LOW_W));
      if (q_rise.size() > nr0 + f) chk({tag, " sclk_rises"}, 32'(q_rise[nr0 + f]), 32'd16);
      if (q_mosi.size() > nm0 + f) chk({tag, " mosi_word"}, 32'(q_mosi[nm0 + f]), 32'(exp_mosi));
    end
    if (q_high.size() > 0) chk({tag, " gap_width"}, 32'(q_high[$]), 32'(GAP));
  endtask

  int idle_bad;
  int t_rst;

  initial begin
    // Reset and idle behaviour.
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst ss_n", 32'(SS_n), 32'd1);
    chk("rst sclk", 32'(SCLK), 32'd1);
    chk("rst mosi", 32'(MOSI), 32'd0);
    chk("rst cmplt", 32'(cnv_cmplt), 32'd0);
    chk("rst res", 32'(res), 32'd0);
    idle_bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (SS_n !== 1'b1 || SCLK !== 1'b1 || cnv_cmplt !== 1'b0 || res !== 12'h000) idle_bad++;
    end
    chk("idle quiet", 32'(idle_bad), 32'd0);

    // Directed conversions.
    do_conv(3'b101, 12'hA5C, 0, 3'b000, "ch5");
    do_conv(3'b110, 12'h3F0, 0, 3'b000, "b2b");
    do_conv(3'b001, 12'($urandom), 300, 3'b111, "ignore");
    do_conv(3'b000, 12'hFFF, 0, 3'b000, "allones");

    // Randomized conversions.
    for (int i = 0; i < 3; i++) begin
      do_conv(3'($urandom), 12'($urandom), 0, 3'b000, "rnd");
    end

    // Reset mid-frame 2 aborts the transaction.
    adc_word = 16'($urandom);
    @(negedge clk);
    strt_cnv = 1'b1;
    chnnl    = 3'($urandom);
    @(negedge clk);
    strt_cnv = 1'b0;
    t_rst = cyc;
    while (cyc - t_rst < 699) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst ss_n", 32'(SS_n), 32'd1);
    chk("midrst sclk", 32'(SCLK), 32'd1);
    chk("midrst res", 32'(res), 32'd0);
    chk("midrst cmplt", 32'(cnv_cmplt), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    idle_bad = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (SS_n !== 1'b1 || cnv_cmplt !== 1'b0 || res !== 12'h000) idle_bad++;
    end
    chk("post_rst quiet", 32'(idle_bad), 32'd0);
    do_conv(3'($urandom), 12'($urandom), 0, 3'b000, "after_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/a2d_spi_intf.md
A2D_SPI_INTF -- requirements
Module: a2d_spi_intf

Interface
REQ-001 Parameter: GAP_CLKS, default 32, count of clk cycles SS_n is held high between frame 1 and frame 2 (legal range 2..255).
REQ-002 clk  input  1  system clock; all state changes on its rising edge.
REQ-003 rst  input  1  asynchronous reset, active high.
REQ-004 strt_cnv  input  1  single-cycle request to convert the channel on chnnl.
REQ-005 chnnl  input  3  ADC channel select, sampled when strt_cnv is accepted.
REQ-006 MISO  input  1  serial data from the ADC.
REQ-007 SS_n  output  1  active-low ADC chip select.
REQ-008 SCLK  output  1  serial clock to the ADC, clk/32.
REQ-009 MOSI  output  1  serial data to the ADC, always equal to shift-register bit 15.
REQ-010 cnv_cmplt  output  1  conversion-done flag, held until the next accepted strt_cnv.
REQ-011 res  output  12  last conversion result.

Function
REQ-012 FSM states SHALL be: IDLE, FRM1, GAP, FRM2, DONE; each transaction SHALL consist of two 16-bit SPI frames.
REQ-013 strt_cnv SHALL be accepted only in IDLE or DONE; on acceptance: latch chnnl, load shift reg {2'b00, chnnl, 11'h000}, clear cnv_cmplt, go to FRM1.
REQ-014 strt_cnv in FRM1, GAP or FRM2 SHALL be ignored, including any chnnl change.
REQ-015 SS_n SHALL go low on the edge after the one that accepts strt_cnv (E0), i.e. at E1.
REQ-016 A 5-bit divider SHALL be loaded with 5'b10111 when a frame starts, increment every clk while SS_n is low, and drive SCLK = divider[4]; SCLK SHALL be 1 whenever SS_n is high.
REQ-017 SCLK rising edge = divider 01111->10000; on that clk edge the shift reg SHALL shift left with MISO into bit 0 and a 5-bit rise counter SHALL increment.
REQ-018 Shifting on any other cycle is prohibited.
REQ-019 After the 16th rise, when the divider reaches 5'b11110, SS_n SHALL return high on the next edge; each frame is SS_n low exactly 520 clk cycles with exactly 16 SCLK rises.
REQ-020 GAP SHALL hold SS_n high for GAP_CLKS cycles, then start FRM2; FRM2 reloads the shift reg with {2'b00, latched chnnl, 11'h000}.
REQ-021 At the end of FRM2, res SHALL load shift reg [11:0] and cnv_cmplt SHALL assert on the same edge on which SS_n returns high; FSM goes to DONE.
REQ-022 Total latency with default GAP_CLKS: SS_n low E1..E520, high E521..E552, low E553..E1072; cnv_cmplt=1 and res valid at E1073.
REQ-023 In DONE, cnv_cmplt and res SHALL hold until strt_cnv is accepted; res SHALL keep its old value during a new conversion until REQ-021.
REQ-024 Frame-1 MISO data SHALL be discarded; only frame-2 data updates res.
REQ-025 The rise counter SHALL never wrap within a frame; it SHALL clear at every frame start.

Reset
REQ-026 On rst high, asynchronously: state=IDLE, SS_n=1, SCLK=1, MOSI=0 (shift reg 0), cnv_cmplt=0, res=12'h000, divider and counters 0.
REQ-027 rst asserted mid-frame SHALL abort immediately with SS_n high; no partial result SHALL reach res; after release, the block SHALL accept a new strt_cnv normally.

Verification
REQ-028 Reset then idle 100 clks -> SS_n=1, SCLK=1, cnv_cmplt=0, res=0, no SCLK toggles.
REQ-029 strt_cnv with chnnl=3'b101, ADC model returning 12'hA5C -> MOSI bits 15..0 = 0010_1000_0000_0000 in both frames; res=12'hA5C; cnv_cmplt rises at E1073.
REQ-030 Count SCLK rises per SS_n-low window -> exactly 16; SS_n low width 520 clks; gap high width 32 clks.
REQ-031 Pulse strt_cnv with chnnl=3'b111 at E300 during a chnnl=3'b001 conversion -> ignored; frame 2 MOSI still carries channel 1; cnv_cmplt at E1073.
REQ-032 Back-to-back: strt_cnv in DONE with res=12'hA5C -> cnv_cmplt clears next edge; res stays 12'hA5C until the new result (e.g. 12'h3F0) loads.
REQ-033 rst pulse at E700 -> SS_n=1 immediately, res=0, cnv_cmplt=0; a subsequent conversion completes 1073 cycles after acceptance.
